// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//
// Bundles the signals of the instruction fetch stage into one interface:
//   - Instruction memory request and response:
//     imem_req, imem_addr, imem_gnt, imem_rvalid, imem_rdata
//   - Redirect input from branch/jump resolution:
//     redirect, redirect_pc
//   - Valid/ready hand-off toward decode:
//     out_valid, out_ready, instruct, typ, pc_out
//   - Misaligned-redirect flag:
//     fault
//
// Modports:
//   master - the fetch unit side. It drives the requests and the decode outputs.
//   slave  - the environment side (memory, branch unit and decode).
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        redirect;
    logic [31:0] redirect_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruct;
    logic [6:0]  typ;
    logic [31:0] pc_out;

    logic        fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output out_valid, instruct, typ, pc_out,
        input  out_ready,
        output fault
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  out_valid, instruct, typ, pc_out,
        output out_ready,
        input  fault
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the RISC-V single-cycle core.
//   - Holds the program counter.
//   - Issues one word request at a time to instruction memory.
//   - Captures the returned word.
//   - Hands the word and its PC to decode through a valid/ready handshake.
//   - On a redirect, loads a new PC and discards any stale in-flight response.
//
// Parameters:
//   RESET_PC - PC loaded on reset. It must be word-aligned.
//
// Ports:
//   clk - system clock. All state changes on the rising edge.
//   rst - asynchronous, active-high reset.
//   bus - fetch_unit_if.master, which carries:
//         imem_*   memory request and response
//         redirect redirect pulse and target PC
//         out_*    decode handshake, with instruct, typ and pc_out
//         fault    misaligned-redirect flag
//
// Optional feature, enabled by defining the macro FETCH_ALIGN_CHECK_EN:
//   - A redirect to a misaligned target parks the unit in a FAULT state.
//   - The unit leaves FAULT only on reset or on an aligned redirect.
//   - Without the macro, the low two bits of the target are forced to zero
//     and fault is tied low.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
        , ST_FAULT = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;   // address of the outstanding request
    logic        discard_q, discard_d;     // the next response is stale
    logic [31:0] instruct_q, instruct_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] target;

    assign target = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^bus.redirect_pc[1:0];
`endif

    // Outputs follow directly from the registered state.
    assign bus.imem_req  = (state_q == ST_FETCH) && !rst;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.instruct  = instruct_q;
    assign bus.typ       = instruct_q[6:0];
    assign bus.pc_out    = pc_out_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.fault     = (state_q == ST_FAULT);
`else
    assign bus.fault     = 1'b0;
`endif

    // NOTE: every next-state value is first defaulted to its current value.
    // Without these defaults, a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        instruct_d = instruct_q;
        pc_out_d   = pc_out_q;

        if (bus.redirect) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned) begin
                state_d = ST_FAULT;
                pc_d    = bus.redirect_pc;
                // Remember whether a response is still owed by the memory.
                // That response must not be taken as the first word after recovery.
                unique case (state_q)
                    ST_FETCH: discard_d = bus.imem_gnt;
                    ST_WAIT:  discard_d = !bus.imem_rvalid;
                    ST_FAULT: discard_d = discard_q && !bus.imem_rvalid;
                    default:  discard_d = 1'b0;
                endcase
            end else
`endif
            begin
                pc_d    = target;
                state_d = ST_FETCH;
                unique case (state_q)
                    ST_FETCH: begin
                        // A request granted in this cycle now targets the old PC.
                        if (bus.imem_gnt) begin
                            state_d   = ST_WAIT;
                            discard_d = 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.imem_rvalid) begin
                            discard_d = 1'b0;
                        end else begin
                            state_d   = ST_WAIT;
                            discard_d = 1'b1;
                        end
                    end
`ifdef FETCH_ALIGN_CHECK_EN
                    ST_FAULT: discard_d = discard_q && !bus.imem_rvalid;
`endif
                    default: ;
                endcase
            end
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (bus.imem_gnt) begin
                        req_addr_d = pc_q;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = ST_FETCH;
                        end else begin
                            instruct_d = bus.imem_rdata;
                            pc_out_d   = req_addr_q;
                            state_d    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_FETCH;
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                ST_FAULT: begin
                    if (bus.imem_rvalid) discard_d = 1'b0;
                end
`endif
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // All registers then update together on the edge, with no ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            discard_q  <= 1'b0;
            // NOTE: the output data registers are reset along with the control state.
            // Decode therefore never observes X on instruct/pc_out.
            instruct_q <= '0;
            pc_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            instruct_q <= instruct_d;
            pc_out_q   <= pc_out_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit.
//   - Inputs are driven on the falling edge.
//   - Outputs are sampled on the falling edge, away from the active rising edge.
//   - Expected values are written out by hand in the stimulus.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // FETCH cycle: expect a request to addr, then grant it.
    task automatic issue(input logic [31:0] addr);
        check("imem_req", {31'd0, bus.imem_req}, 32'd1);
        check("imem_addr", bus.imem_addr, addr);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        check("req_in_wait", {31'd0, bus.imem_req}, 32'd0);
    endtask

    task automatic respond(input logic [31:0] data);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
    endtask

    // HOLD cycle: expect the word on the decode outputs, then consume it.
    task automatic consume(input logic [31:0] word, input logic [31:0] pc);
        logic [6:0] op;
        op = word[6:0];
        check("out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("instruct", bus.instruct, word);
        check("typ", {25'd0, bus.typ}, {25'd0, op});
        check("pc_out", bus.pc_out, pc);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.out_ready   = 1'b0;

        // Reset values.
        step();
        step();
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_instruct", bus.instruct, 32'd0);
        check("rst_typ", {25'd0, bus.typ}, 32'd0);
        check("rst_pc_out", bus.pc_out, 32'd0);
        check("rst_fault", {31'd0, bus.fault}, 32'd0);
        rst = 1'b0;
        #1;

        // Straight-line fetch: addresses 0, 4, 8.
        issue(32'h0000_0000);
        respond(32'h0050_0093);
        consume(32'h0050_0093, 32'h0000_0000);
        issue(32'h0000_0004);
        respond(32'h00A0_0113);
        consume(32'h00A0_0113, 32'h0000_0004);
        issue(32'h0000_0008);
        respond(32'h0030_8193);

        // Decode stalls for 5 cycles. The outputs hold and no request is issued.
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_instruct", bus.instruct, 32'h0030_8193);
            check("hold_pc_out", bus.pc_out, 32'h0000_0008);
            check("hold_req", {31'd0, bus.imem_req}, 32'd0);
            step();
        end
        consume(32'h0030_8193, 32'h0000_0008);
        issue(32'h0000_000C);

        // Redirect while waiting. The late response is dropped.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        step();
        bus.redirect = 1'b0;
        check("wait_redir_req", {31'd0, bus.imem_req}, 32'd0);
        respond(32'hDEAD_BEEF);
        check("stale_dropped", {31'd0, bus.out_valid}, 32'd0);
        issue(32'h0000_0100);
        respond(32'h0001_22B7);
        consume(32'h0001_22B7, 32'h0000_0100);

        // Redirect and ready in the same HOLD cycle: the target wins over pc+4.
        issue(32'h0000_0104);
        respond(32'h0000_0013);
        check("hold2_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        bus.out_ready   = 1'b1;
        step();
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b0;
        check("hold_redir_valid", {31'd0, bus.out_valid}, 32'd0);

        // Redirect in FETCH without a grant, then check PC wrap-around.
        check("fetch_addr_40", bus.imem_addr, 32'h0000_0040);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        issue(32'hFFFF_FFFC);
        respond(32'h0000_006F);
        consume(32'h0000_006F, 32'hFFFF_FFFC);
        issue(32'h0000_0000);
        respond(32'h0010_0073);
        consume(32'h0010_0073, 32'h0000_0000);

        // Redirect in the same cycle as the grant. That response is stale.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0080;
        bus.imem_gnt    = 1'b1;
        step();
        bus.redirect = 1'b0;
        bus.imem_gnt = 1'b0;
        check("gnt_redir_wait", {31'd0, bus.imem_req}, 32'd0);
        respond(32'h0BAD_C0DE);
        check("gnt_redir_drop", {31'd0, bus.out_valid}, 32'd0);
        issue(32'h0000_0080);
        respond(32'h0000_8067);
        consume(32'h0000_8067, 32'h0000_0080);

        // Reset in the middle of a transaction.
        issue(32'h0000_0084);
        rst = 1'b1;
        #1;
        check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        check("midrst_instruct", bus.instruct, 32'd0);
        rst = 1'b0;
        #1;
        issue(32'h0000_0000);
        respond(32'h0020_0193);
        consume(32'h0020_0193, 32'h0000_0000);

        // Misaligned redirect.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        step();
        bus.redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 10; i++) begin
            check("fault_set", {31'd0, bus.fault}, 32'd1);
            check("fault_req", {31'd0, bus.imem_req}, 32'd0);
            check("fault_valid", {31'd0, bus.out_valid}, 32'd0);
            step();
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        step();
        bus.redirect = 1'b0;
        check("fault_clear", {31'd0, bus.fault}, 32'd0);
        issue(32'h0000_0200);
        respond(32'h0000_0517);
        consume(32'h0000_0517, 32'h0000_0200);
`else
        check("nofault", {31'd0, bus.fault}, 32'd0);
        issue(32'h0000_0100);
        check("nofault_wait", {31'd0, bus.fault}, 32'd0);
        respond(32'h0000_0517);
        consume(32'h0000_0517, 32'h0000_0100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V single-cycle core. Holds the program counter, issues one word request at a time to instruction memory, and captures the returned word. Presents the word and its PC to decode through a valid/ready handshake. `typ` is the opcode field (`instruct[6:0]`) and drives the sign-extension stage directly. Accepts PC redirects from branch/jump resolution and discards any in-flight stale response.

## Interface
- `RESET_PC`, default 32'h00000000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  request valid toward instruction memory.
- `imem_addr`  out  32  word address of the request (bits [1:0] always 0).
- `imem_gnt`  in  1  memory accepts the request in this cycle.
- `imem_rvalid`  in  1  response word valid.
- `imem_rdata`  in  32  response word.
- `redirect`  in  1  single-cycle pulse: load a new PC.
- `redirect_pc`  in  32  new PC target.
- `out_valid`  out  1  `instruct`/`typ`/`pc_out` are valid for decode.
- `out_ready`  in  1  decode consumes the word in this cycle.
- `instruct`  out  32  captured instruction word.
- `typ`  out  7  `instruct[6:0]`.
- `pc_out`  out  32  address the word was fetched from.
- `fault`  out  1  misaligned redirect flag (see Configuration).

## Operation
- States: FETCH, WAIT, HOLD, plus FAULT when the macro is enabled.
- FETCH: `imem_req`=1 and `imem_addr`=pc. On `imem_gnt`, latch pc into the request-address register and go to WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`:
  - If the discard flag is set, drop the word, clear the flag, and go to FETCH.
  - Otherwise, register `imem_rdata` into `instruct`, set `pc_out` to the request address, set `out_valid`, and go to HOLD.
- HOLD: `out_valid`=1, and `instruct`/`typ`/`pc_out` are held stable. On `out_ready`: pc ← pc+4 (mod 2^32, wraps 0xFFFFFFFC→0), clear `out_valid`, go to FETCH.
- At most one request outstanding. Responses arriving outside WAIT are ignored.
- Redirect has priority over every other event in the same cycle:
  - FETCH, no `imem_gnt`: pc ← `redirect_pc`; stay in FETCH. `imem_addr` may change before grant.
  - FETCH with `imem_gnt` in the same cycle: pc ← `redirect_pc`, set discard flag, go to WAIT.
  - WAIT without `imem_rvalid`: pc ← `redirect_pc`, set discard flag, stay in WAIT.
  - WAIT with `imem_rvalid`: drop the word, pc ← `redirect_pc`, go to FETCH.
  - HOLD (with or without `out_ready`): drop the held word, clear `out_valid`, pc ← `redirect_pc`, go to FETCH. pc is not incremented.
- Reset values: pc=`RESET_PC`, state=FETCH, discard=0, `out_valid`=0, `instruct`=0, `typ`=0, `pc_out`=0, `fault`=0. `imem_req` is forced to 0 while `rst` is high.
- Reset asserted mid-transaction abandons the request. The memory side is reset by the same `rst`.

## Timing
- First `imem_req` occurs in the first cycle after `rst` deasserts.
- `imem_rvalid` arrives no earlier than the cycle after `imem_gnt`.
- `out_valid` rises in the cycle after `imem_rvalid`.
- Best case (gnt immediate, rvalid +1, ready immediate): one instruction every 3 cycles.
- Redirect takes effect on the next edge. The first request to the target issues the cycle after redirect, or the cycle after a discarded response lands.
- `out_valid` never drops without a handshake, except on redirect or reset.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 enters FAULT. In FAULT: `fault`=1, `imem_req`=0, `out_valid`=0, pc is loaded with the raw target.
  - Any in-flight response is discarded.
  - FAULT exits only on reset or on an aligned redirect, which goes to FETCH and clears `fault`.
- Not defined: `redirect_pc[1:0]` is forced to 0, the FAULT state does not exist, and `fault` is tied 0.

## Test plan
- Reset release with `RESET_PC`=0, gnt always 1, rvalid one cycle later returning 0x00500093, ready=1: `imem_addr` sequence is 0, 4, 8. `out_valid` pulses with `instruct`=0x00500093, `typ`=7'b0010011, `pc_out`=0.
- Hold `out_ready`=0 for 5 cycles in HOLD: outputs stay stable, `imem_req`=0, pc is not incremented. Release ready: next `imem_addr`=pc+4.
- Redirect to 0x100 in WAIT (rvalid 2 cycles later returns 0xDEADBEEF): the word is dropped and `out_valid` stays 0. Next `imem_addr`=0x100, and `pc_out`=0x100 on the delivered word.
- Redirect to 0x40 and `out_ready` in the same HOLD cycle: the held word is dropped, pc becomes 0x40, not old pc+4.
- With pc=0xFFFFFFFC and handshake complete: next `imem_addr`=0x00000000.
- `FETCH_ALIGN_CHECK_EN`: redirect to 0x102 gives `fault`=1 and no requests for 10 cycles. Redirect to 0x200 clears `fault` and issues `imem_addr`=0x200. Without the macro, the same stimulus issues `imem_addr`=0x100 and `fault` stays 0.
